// File: rtl/sym_player_pkg.sv
// Shared definitions for the symbol player: state encoding, symbol and LED widths.
package sym_player_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((32'sd1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int SYM_W    = 2;
    localparam int LED_W    = 4;
    localparam int N_STATES = 6;
    localparam int ST_W     = clog2(N_STATES);

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 3'd0,
        ST_POP  = 3'd1,
        ST_CAP  = 3'd2,
        ST_ON   = 3'd3,
        ST_OFF  = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

    typedef logic [SYM_W-1:0] sym_t;
    typedef logic [LED_W-1:0] led_t;

endpackage

// File: rtl/sym_player_decode.sv
// 2-to-4 one-hot decoder mapping a stored symbol to its LED pattern.
module sym_decode
    import sym_player_pkg::*;
(
    input  sym_t sym,
    output led_t led
);

    // One-hot decode of the symbol value
    always_comb begin
        case (sym)
            2'd0:    led = 4'b0001;
            2'd1:    led = 4'b0010;
            2'd2:    led = 4'b0100;
            2'd3:    led = 4'b1000;
            default: led = 4'b0000;
        endcase
    end

endmodule

// File: rtl/sym_player.sv
// Drains a symbol stack, showing each symbol on a one-hot LED for ON_TICKS
// prescaler strobes followed by an OFF_TICKS blank gap.
module sym_player
    import sym_player_pkg::*;
#(
    parameter int DATA_WIDTH = 2,
    parameter int ON_TICKS   = 8,
    parameter int OFF_TICKS  = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic                  ABORT,
    input  logic                  TICK,
    input  logic [DATA_WIDTH-1:0] STK_DATA,
    input  logic                  STK_EMPTY,
    output logic                  STK_POP,
    output logic [LED_W-1:0]      LED,
    output logic                  BUSY,
    output logic                  DONE
);

    localparam logic [CNT_WIDTH-1:0] ON_LOAD  = CNT_WIDTH'(ON_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] OFF_LOAD = CNT_WIDTH'(OFF_TICKS - 1);

    state_t               state_r;
    sym_t                 sym_r;
    logic [CNT_WIDTH-1:0] cnt_r;
    led_t                 dec_s;
    led_t                 led_s;
    logic                 abort_s;

    // FIN is already the terminating state, so ABORT only redirects active playback
    assign abort_s = ABORT && (state_r != ST_IDLE) && (state_r != ST_FIN);

    // Playback sequencer: state, captured symbol and tick down-counter
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
            sym_r   <= {SYM_W{1'b0}};
            cnt_r   <= {CNT_WIDTH{1'b0}};
        end else if (abort_s) begin
            state_r <= ST_FIN;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (START) begin
                        state_r <= STK_EMPTY ? ST_FIN : ST_POP;
                    end
                end
                ST_POP: begin
                    state_r <= ST_CAP;
                end
                ST_CAP: begin
                    sym_r   <= STK_DATA;
                    cnt_r   <= ON_LOAD;
                    state_r <= ST_ON;
                end
                ST_ON: begin
                    if (TICK) begin
                        if (cnt_r == {CNT_WIDTH{1'b0}}) begin
                            cnt_r   <= OFF_LOAD;
                            state_r <= ST_OFF;
                        end else begin
                            cnt_r <= cnt_r - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_OFF: begin
                    if (TICK) begin
                        if (cnt_r == {CNT_WIDTH{1'b0}}) begin
                            state_r <= STK_EMPTY ? ST_FIN : ST_POP;
                        end else begin
                            cnt_r <= cnt_r - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_FIN: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    sym_decode u_decode (
        .sym (sym_r),
        .led (dec_s)
    );

    // LED is lit only while a symbol is on display
    always_comb begin
        if (state_r == ST_ON) begin
            led_s = dec_s;
        end else begin
            led_s = {LED_W{1'b0}};
        end
    end

    assign LED     = led_s;
    assign STK_POP = (state_r == ST_POP);
    assign BUSY    = (state_r != ST_IDLE);
    assign DONE    = (state_r == ST_FIN);

endmodule

// File: tb/tb_sym_player.sv
// Directed bench for sym_player with ON_TICKS=2, OFF_TICKS=1 and a small stack model.
module tb_sym_player;

    logic       CLK;
    logic       RST_N;
    logic       START;
    logic       ABORT;
    logic       TICK;
    logic [1:0] STK_DATA;
    logic       STK_EMPTY;
    logic       STK_POP;
    logic [3:0] LED;
    logic       BUSY;
    logic       DONE;

    int errors = 0;
    int checks = 0;

    // Stack model: mem[0] is the bottom, mem[sp-1] the top
    logic [1:0] mem [0:3];
    logic [2:0] sp;
    logic [2:0] ld_n;
    logic       ld_req;
    int         pop_cnt;

    // Cycle-by-cycle expectations for stack 2,0,3 with TICK high every cycle (cycles 1..17)
    localparam logic [3:0] SEQ_LED [0:16] = '{
        4'h0, 4'h0, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1,
        4'h0, 4'h0, 4'h0, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0};
    localparam logic [16:0] SEQ_POP  = 17'h00421;
    localparam logic [16:0] SEQ_DONE = 17'h08000;
    localparam logic [16:0] SEQ_BUSY = 17'h0FFFF;

    sym_player #(
        .DATA_WIDTH (2),
        .ON_TICKS   (2),
        .OFF_TICKS  (1),
        .CNT_WIDTH  (8)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .START     (START),
        .ABORT     (ABORT),
        .TICK      (TICK),
        .STK_DATA  (STK_DATA),
        .STK_EMPTY (STK_EMPTY),
        .STK_POP   (STK_POP),
        .LED       (LED),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign STK_EMPTY = (sp == 3'd0);

    // Stack behaviour: pop data appears the cycle after STK_POP
    always @(posedge CLK) begin
        if (ld_req) begin
            sp      <= ld_n;
            pop_cnt <= 0;
        end else if (STK_POP) begin
            pop_cnt <= pop_cnt + 1;
            if (sp != 3'd0) begin
                STK_DATA <= mem[sp - 3'd1];
                sp       <= sp - 3'd1;
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // a is the top of stack, c the bottom
    task automatic load_stack(input logic [2:0] n, input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
        mem[0] = (n == 3'd3) ? c : (n == 3'd2) ? b : a;
        mem[1] = (n == 3'd3) ? b : a;
        mem[2] = a;
        ld_n   = n;
        ld_req = 1'b1;
        step();
        ld_req = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        #3;
        checks++; if (LED !== 4'b0000) begin errors++; $display("FAIL reset_led got=%b exp=%b", LED, 4'b0000); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=%b", BUSY, 1'b0); end
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=%b", DONE, 1'b0); end
        checks++; if (STK_POP !== 1'b0) begin errors++; $display("FAIL reset_pop got=%b exp=%b", STK_POP, 1'b0); end
        step();
        step();
        RST_N = 1'b1;
        step();
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got=%b exp=%b", BUSY, 1'b0); end
    endtask

    task automatic run_seq(input string name, input logic [16:0] start_mask);
        logic [3:0]  led_e;
        logic [16:0] pop_v;
        logic [16:0] done_v;
        logic [16:0] busy_v;
        logic [16:0] st_v;
        pop_v  = SEQ_POP;
        done_v = SEQ_DONE;
        busy_v = SEQ_BUSY;
        st_v   = start_mask;
        load_stack(3'd3, 2'd2, 2'd0, 2'd3);
        TICK  = 1'b1;
        START = 1'b1;
        step();
        START = 1'b0;
        for (int i = 0; i < 17; i++) begin
            led_e = SEQ_LED[i];
            checks++; if (LED !== led_e) begin errors++; $display("FAIL %s_led cyc=%0d got=%b exp=%b", name, i + 1, LED, led_e); end
            checks++; if (STK_POP !== pop_v[i]) begin errors++; $display("FAIL %s_pop cyc=%0d got=%b exp=%b", name, i + 1, STK_POP, pop_v[i]); end
            checks++; if (DONE !== done_v[i]) begin errors++; $display("FAIL %s_done cyc=%0d got=%b exp=%b", name, i + 1, DONE, done_v[i]); end
            checks++; if (BUSY !== busy_v[i]) begin errors++; $display("FAIL %s_busy cyc=%0d got=%b exp=%b", name, i + 1, BUSY, busy_v[i]); end
            START = st_v[i];
            step();
        end
        START = 1'b0;
        checks++; if (pop_cnt !== 3) begin errors++; $display("FAIL %s_pop_count got=%0d exp=%0d", name, pop_cnt, 3); end
        checks++; if (sp !== 3'd0) begin errors++; $display("FAIL %s_stack_left got=%0d exp=%0d", name, sp, 0); end
    endtask

    task automatic test_sequence();
        run_seq("seq", 17'h00000);
    endtask

    task automatic test_start_repeat();
        run_seq("restart", 17'h0108C);
    endtask

    task automatic test_empty();
        load_stack(3'd0, 2'd0, 2'd0, 2'd0);
        START = 1'b1;
        step();
        START = 1'b0;
        checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL empty_done got=%b exp=%b", DONE, 1'b1); end
        checks++; if (STK_POP !== 1'b0) begin errors++; $display("FAIL empty_pop got=%b exp=%b", STK_POP, 1'b0); end
        checks++; if (LED !== 4'b0000) begin errors++; $display("FAIL empty_led got=%b exp=%b", LED, 4'b0000); end
        step();
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL empty_done_end got=%b exp=%b", DONE, 1'b0); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL empty_busy got=%b exp=%b", BUSY, 1'b0); end
        checks++; if (pop_cnt !== 0) begin errors++; $display("FAIL empty_pop_count got=%0d exp=%0d", pop_cnt, 0); end
    endtask

    task automatic test_abort_on();
        load_stack(3'd3, 2'd2, 2'd0, 2'd3);
        TICK  = 1'b1;
        START = 1'b1;
        step();
        START = 1'b0;
        for (int i = 1; i < 8; i++) step();
        checks++; if (LED !== 4'b0001) begin errors++; $display("FAIL abort_pre_led got=%b exp=%b", LED, 4'b0001); end
        ABORT = 1'b1;
        step();
        ABORT = 1'b0;
        checks++; if (LED !== 4'b0000) begin errors++; $display("FAIL abort_led got=%b exp=%b", LED, 4'b0000); end
        checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL abort_done got=%b exp=%b", DONE, 1'b1); end
        checks++; if (STK_POP !== 1'b0) begin errors++; $display("FAIL abort_pop got=%b exp=%b", STK_POP, 1'b0); end
        step();
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=%b", BUSY, 1'b0); end
        checks++; if (sp !== 3'd1) begin errors++; $display("FAIL abort_stack_left got=%0d exp=%0d", sp, 1); end
        checks++; if (pop_cnt !== 2) begin errors++; $display("FAIL abort_pop_count got=%0d exp=%0d", pop_cnt, 2); end
    endtask

    task automatic test_abort_pop();
        load_stack(3'd2, 2'd1, 2'd3, 2'd0);
        START = 1'b1;
        step();
        START = 1'b0;
        checks++; if (STK_POP !== 1'b1) begin errors++; $display("FAIL abortpop_pop got=%b exp=%b", STK_POP, 1'b1); end
        ABORT = 1'b1;
        step();
        ABORT = 1'b0;
        checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL abortpop_done got=%b exp=%b", DONE, 1'b1); end
        checks++; if (LED !== 4'b0000) begin errors++; $display("FAIL abortpop_led got=%b exp=%b", LED, 4'b0000); end
        step();
        checks++; if (sp !== 3'd1) begin errors++; $display("FAIL abortpop_stack_left got=%0d exp=%0d", sp, 1); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL abortpop_busy got=%b exp=%b", BUSY, 1'b0); end
    endtask

    task automatic test_tick_hold();
        int bad;
        bad = 0;
        load_stack(3'd1, 2'd1, 2'd0, 2'd0);
        TICK  = 1'b1;
        START = 1'b1;
        step();
        START = 1'b0;
        step();
        step();
        TICK = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (LED !== 4'b0010) bad++;
            step();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL hold_led_cycles got=%0d exp=%0d", bad, 0); end
        TICK = 1'b1;
        step();
        checks++; if (LED !== 4'b0010) begin errors++; $display("FAIL hold_first_tick_led got=%b exp=%b", LED, 4'b0010); end
        step();
        checks++; if (LED !== 4'b0000) begin errors++; $display("FAIL hold_off_led got=%b exp=%b", LED, 4'b0000); end
        step();
        checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL hold_done got=%b exp=%b", DONE, 1'b1); end
        step();
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL hold_busy got=%b exp=%b", BUSY, 1'b0); end
    endtask

    task automatic test_reset_mid();
        int dones;
        dones = 0;
        load_stack(3'd2, 2'd3, 2'd1, 2'd0);
        TICK  = 1'b1;
        START = 1'b1;
        step();
        START = 1'b0;
        for (int i = 1; i < 5; i++) step();
        checks++; if (BUSY !== 1'b1 || LED !== 4'b0000) begin errors++; $display("FAIL rstmid_in_off got=%b/%b exp=1/0000", BUSY, LED); end
        #2;
        RST_N = 1'b0;
        #1;
        checks++; if ({LED, BUSY, DONE, STK_POP} !== 7'b0) begin errors++; $display("FAIL rstmid_async got=%b exp=%b", {LED, BUSY, DONE, STK_POP}, 7'b0); end
        step();
        RST_N = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (DONE !== 1'b0) dones++;
            step();
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL rstmid_no_done got=%0d exp=%0d", dones, 0); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rstmid_idle got=%b exp=%b", BUSY, 1'b0); end
    endtask

    initial begin
        START    = 1'b0;
        ABORT    = 1'b0;
        TICK     = 1'b0;
        RST_N    = 1'b0;
        ld_req   = 1'b0;
        ld_n     = 3'd0;
        sp       = 3'd0;
        pop_cnt  = 0;
        STK_DATA = 2'd0;
        for (int i = 0; i < 4; i++) mem[i] = 2'd0;
        test_reset();
        test_sequence();
        test_empty();
        test_start_repeat();
        test_abort_on();
        test_abort_pop();
        test_tick_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sym_player.md
SYM_PLAYER -- requirements
Module: sym_player

Interface
REQ-001 Parameter DATA_WIDTH, default 2, symbol width; fixed at 2 (4 symbols).
REQ-002 Parameter ON_TICKS, default 8, TICK strobes each symbol is displayed; legal range 1..2^CNT_WIDTH.
REQ-003 Parameter OFF_TICKS, default 4, TICK strobes of blank gap after each symbol; legal range 1..2^CNT_WIDTH.
REQ-004 Parameter CNT_WIDTH, default 8, width of the tick down-counter.
REQ-005 CLK  input  1  clock, all state updates on the rising edge.
REQ-006 RST_N  input  1  reset, asynchronous, active-low.
REQ-007 START  input  1  one-cycle request to begin draining the stack.
REQ-008 ABORT  input  1  synchronous request to stop playback.
REQ-009 TICK  input  1  one-cycle prescaler strobe (slow time base).
REQ-010 STK_DATA  input  DATA_WIDTH  stack read data, valid the cycle after STK_POP.
REQ-011 STK_EMPTY  input  1  stack empty flag.
REQ-012 STK_POP  output  1  one-cycle pop request to the stack.
REQ-013 LED  output  4  one-hot decoded symbol; all zero when not displaying.
REQ-014 BUSY  output  1  high in every state except IDLE.
REQ-015 DONE  output  1  one-cycle pulse when playback ends (normal, empty, or aborted).

Function
REQ-016 States: IDLE, POP, CAP, ON, OFF, FIN; all transitions on the rising CLK edge.
REQ-017 IDLE: START=1 and STK_EMPTY=0 -> POP; START=1 and STK_EMPTY=1 -> FIN; otherwise stay.
REQ-018 POP: STK_POP=1 for exactly this one cycle -> CAP.
REQ-019 CAP: STK_DATA registered into sym; counter loaded with ON_TICKS-1 -> ON.
REQ-020 ON: LED = decode(sym): 0->0001, 1->0010, 2->0100, 3->1000; TICK with counter=0 -> OFF with counter loaded OFF_TICKS-1; TICK with counter>0 decrements.
REQ-021 OFF: LED=0000; TICK with counter=0 -> POP if STK_EMPTY=0, else FIN; TICK with counter>0 decrements.
REQ-022 FIN: DONE=1 for this one cycle -> IDLE.
REQ-023 Pop-to-LED latency: STK_POP in cycle N, LED valid in cycle N+2.
REQ-024 ON lasts exactly ON_TICKS TICK strobes; OFF lasts exactly OFF_TICKS TICK strobes; cycles without TICK never change the counter.
REQ-025 Counter never wraps; decrement occurs only when counter>0.
REQ-026 STK_POP never asserted while STK_EMPTY=1 is sampled in the deciding state.
REQ-027 START ignored in every state but IDLE.
REQ-028 ABORT in any non-IDLE state except FIN -> FIN next cycle; LED and STK_POP forced 0 that cycle; ABORT takes priority over TICK; ABORT in IDLE ignored.
REQ-029 ABORT in POP: the pop still completes (stack entry consumed) and the popped symbol is discarded.
REQ-030 STK_EMPTY going high during ON/OFF does not affect the current symbol; it is checked only at the end of OFF.

Reset
REQ-031 RST_N=0 forces immediately: state=IDLE, STK_POP=0, LED=0000, BUSY=0, DONE=0, sym=0, counter=0.
REQ-032 Reset mid-playback discards the current symbol; no DONE pulse is issued for the interrupted run.

Structure
REQ-033 State encodings, symbol width and the one-hot LED width live in the shared project header alongside clog2.
REQ-034 One sub-module, sym_decode: combinational 2-to-4 one-hot decoder, instantiated once.
REQ-035 All outputs are driven from registered state or sym; no combinational path from inputs to outputs.

Verification
REQ-036 Stack preloaded 2,0,3; ON_TICKS=2, OFF_TICKS=1; START -> LED 0100, 0001, 1000 in order, each for 2 TICKs with 1-TICK gaps; three STK_POP pulses; DONE once; BUSY low after.
REQ-037 Empty stack, START -> no STK_POP, DONE pulses 1 cycle later, LED stays 0000.
REQ-038 START repeated during ON -> no extra pops, sequence unchanged.
REQ-039 ABORT during second symbol's ON -> LED 0000 next cycle, DONE pulse, remaining entries stay in stack.
REQ-040 TICK held low for 100 cycles during ON -> LED holds the value, counter unchanged.
REQ-041 RST_N asserted mid-OFF -> all outputs zero asynchronously, IDLE after release, no DONE.
